bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 29 ++
 rtl/rr_pick16.sv | 27 ++
 rtl/bus_arbiter.sv | 118 +++++++++++
 tb/tb_bus_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types and frame geometry for the 16-node round-robin bus arbiter.
package bus_arbiter_pkg;

  localparam int NODES        = 16;
  localparam int NODE_W       = 4;
  localparam int BIT_CNT_W    = 7;
  localparam int ADDR_W       = 4;
  localparam int MOD_W        = 2;
  localparam int DATA_W       = 64;
  localparam int CRC_W        = 4;
  localparam int GAP_BITS_DEF = 2;

  // Start bit, source and receiver addresses, mode, payload and CRC.
  localparam int FRAME_BITS_DEF = 1 + 2 * ADDR_W + MOD_W + DATA_W + CRC_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  function automatic logic [NODES-1:0] node_onehot(input logic [NODE_W-1:0] n);
    logic [NODES-1:0] v;
    v    = '0;
    v[n] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping 15 -> 0.
module rr_pick16
  import bus_arbiter_pkg::*;
(
  input  logic [NODES-1:0]  req,
  input  logic [NODE_W-1:0] ptr,
  output logic              valid,
  output logic [NODE_W-1:0] idx
);

  logic [NODE_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    // Offset 16 wraps back to ptr itself, so the last winner is scanned last.
    for (int k = 1; k <= NODES; k++) begin
      cand = ptr + NODE_W'(k);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: round-robin grant, per-frame bit counter, abort detection, inter-frame gap.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int GAP_BITS   = GAP_BITS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NODES-1:0]     req,
  output logic [NODES-1:0]     grant,
  output logic [NODE_W-1:0]    owner,
  output logic                 busy,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic [15:0]          frame_count
);

  localparam int                   GAP_W    = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0]     LAST_GAP = GAP_W'(GAP_BITS - 1);

  state_e               state_q, state_d;
  logic [NODES-1:0]     grant_q, grant_d;
  logic [NODE_W-1:0]    owner_q, owner_d;
  logic [NODE_W-1:0]    ptr_q, ptr_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [15:0]          frame_count_q, frame_count_d;

  logic              pick_valid;
  logic [NODE_W-1:0] pick_idx;
  logic              in_xmit, abort_now, last_now;

  rr_pick16 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign in_xmit   = (state_q == ST_XMIT);
  assign abort_now = in_xmit && !req[owner_q];
  assign last_now  = in_xmit && (bit_cnt_q == LAST_BIT);

  always_comb begin
    // NOTE: every variable gets a default here, so no path can infer a latch.
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    frame_count_d = frame_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d   = ST_XMIT;
          owner_d   = pick_idx;
          ptr_d     = pick_idx;
          grant_d   = node_onehot(pick_idx);
          bit_cnt_d = '0;
        end
      end
      ST_XMIT: begin
        // An owner dropping req on the last bit is an abort, not a completed frame.
        if (abort_now || last_now) begin
          state_d   = ST_GAP;
          grant_d   = '0;
          gap_cnt_d = '0;
          if (!abort_now) frame_count_d = frame_count_q + 16'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == LAST_GAP) state_d = ST_IDLE;
        else gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      owner_q       <= '0;
      ptr_q         <= NODE_W'(NODES - 1);
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      owner_q       <= owner_d;
      ptr_q         <= ptr_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign busy        = (state_q != ST_IDLE);
  assign bit_cnt     = bit_cnt_q;
  assign frame_done  = last_now && !abort_now;
  assign frame_abort = abort_now;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: the driver issues frames and queues their expected outcome;
// a negedge monitor pops an entry when a grant appears and compares it through frame end and gap.
module tb_bus_arbiter;

  localparam int FRAME_BITS = 79;
  localparam int GAP_BITS   = 2;
  localparam int MAX_WAIT   = 64;

  typedef struct {
    int          node;
    bit          aborted;
    int          end_bit;
    logic [15:0] count_before;
    logic [15:0] count_after;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] req   = '0;
  logic [15:0] grant;
  logic [3:0]  owner;
  logic        busy;
  logic [6:0]  bit_cnt;
  logic        frame_done;
  logic        frame_abort;
  logic [15:0] frame_count;

  int          n_vec  = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];
  int          m_ptr   = 15;
  logic [15:0] m_count = '0;
  bit          mon_en  = 1'b0;

  logic [15:0] r_mask;
  bit          r_abort;
  int          r_at;
  int          r_idle;

  bus_arbiter #(.FRAME_BITS(FRAME_BITS), .GAP_BITS(GAP_BITS)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .grant       (grant),
    .owner       (owner),
    .busy        (busy),
    .bit_cnt     (bit_cnt),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .frame_count (frame_count)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first requesting node strictly after the last winner, wrapping 15 -> 0.
  function automatic int rr_winner(input logic [15:0] mask, input int last);
    for (int k = 1; k <= 16; k++)
      if (mask[(last + k) % 16]) return (last + k) % 16;
    return -1;
  endfunction

  // ---------------- monitor ----------------
  exp_t cur;
  int   cyc, start_cyc, gap_left;
  bit   in_frame, expect_idle, expect_grant;

  always @(negedge clock) begin
    if (!mon_en) begin
      in_frame     = 1'b0;
      expect_idle  = 1'b0;
      expect_grant = 1'b0;
      gap_left     = 0;
      cyc          = 0;
      start_cyc    = 0;
    end else begin
      cyc++;
      check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      check("grant_implies_busy", 32'(grant == '0 || busy), 32'd1);
      if (expect_idle) begin
        check("idle_after_gap", 32'(busy), 32'd0);
        expect_idle = 1'b0;
      end
      if (gap_left > 0) begin
        check("gap_grant", 32'(grant), 32'd0);
        check("gap_busy", 32'(busy), 32'd1);
        if (gap_left == GAP_BITS)
          check("count_after_frame", 32'(frame_count), 32'(cur.count_after));
        gap_left--;
        if (gap_left == 0) expect_idle = 1'b1;
      end else if (in_frame) begin
        check("grant_held", 32'(grant), 32'd1 << cur.node);
        if (frame_done || frame_abort) begin
          check("end_is_abort", 32'(frame_abort), 32'(cur.aborted));
          check("end_is_done", 32'(frame_done), 32'(!cur.aborted));
          check("end_bit_cnt", 32'(bit_cnt), 32'(cur.end_bit));
          check("end_cycle", 32'(cyc - start_cyc), 32'(cur.end_bit));
          check("count_at_end", 32'(frame_count), 32'(cur.count_before));
          in_frame = 1'b0;
          gap_left = GAP_BITS;
        end else if (cyc - start_cyc >= FRAME_BITS) begin
          check("frame_overrun", 32'(cyc - start_cyc), 32'(FRAME_BITS - 1));
          in_frame = 1'b0;
        end
      end else begin
        check("no_pulse_outside_frame", 32'({frame_done, frame_abort}), 32'd0);
        if (grant != '0) begin
          if (sb_q.size() == 0) begin
            check("unexpected_grant", 32'(grant), 32'd0);
          end else begin
            cur = sb_q.pop_front();
            check("grant_latency", 32'(expect_grant), 32'd1);
            check("grant_winner", 32'(grant), 32'd1 << cur.node);
            check("owner", 32'(owner), 32'(cur.node));
            check("bit_cnt_start", 32'(bit_cnt), 32'd0);
            in_frame  = 1'b1;
            start_cyc = cyc;
          end
          expect_grant = 1'b0;
        end else begin
          if (expect_grant) check("grant_latency", 32'(grant != '0), 32'd1);
          expect_grant = !busy && (req != '0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_grant(input logic [15:0] mask);
    bit got;
    got = 1'b0;
    for (int i = 0; i < MAX_WAIT && !got; i++) begin
      @(negedge clock);
      got = (grant != '0);
    end
    if (!got) begin
      n_fail++;
      $display("FAIL grant_timeout: no grant for req 0x%h within %0d cycles", mask, MAX_WAIT);
      $fatal(1, "grant timeout");
    end
  endtask

  task automatic do_reset(input bit chk);
    mon_en = 1'b0;
    reset  = 1'b1;
    req    = '0;
    @(posedge clock);
    @(negedge clock);
    if (chk) begin
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bit_cnt", 32'(bit_cnt), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_frame_abort", 32'(frame_abort), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    sb_q.delete();
    m_ptr   = 15;
    m_count = '0;
    mon_en  = 1'b1;
  endtask

  // Called while the DUT is idle or in the first gap cycle; returns in the first gap cycle after the frame.
  task automatic run_txn(input logic [15:0] mask, input bit abort, input int abort_at,
                         input int idle_k, input bit scramble);
    exp_t e;
    int   w;
    if (idle_k > 0) begin
      req = '0;
      repeat (idle_k) @(posedge clock);
      #1;
    end
    w              = rr_winner(mask, m_ptr);
    e.node         = w;
    e.aborted      = abort;
    e.end_bit      = abort ? abort_at : FRAME_BITS - 1;
    e.count_before = m_count;
    if (!abort) m_count = m_count + 16'd1;
    e.count_after  = m_count;
    m_ptr          = w;
    sb_q.push_back(e);
    req = mask;
    wait_grant(mask);
    if (abort) begin
      repeat (abort_at) @(posedge clock);
      #1;
      req = scramble ? (16'($urandom) & ~(16'd1 << w)) : (mask & ~(16'd1 << w));
      @(posedge clock);
      #1;
    end else begin
      repeat (FRAME_BITS / 2) @(posedge clock);
      #1;
      if (scramble) req = 16'($urandom) | (16'd1 << w);
      repeat (FRAME_BITS - FRAME_BITS / 2) @(posedge clock);
      #1;
    end
  endtask

  initial begin
    do_reset(1'b1);

    // Single requester held: done on bit 78, two gap cycles, re-grant after one idle cycle.
    run_txn(16'h0001, 1'b0, 0, 0, 1'b0);
    run_txn(16'h0001, 1'b0, 0, 0, 1'b0);

    // Two requesters alternate 0,1,0.
    do_reset(1'b0);
    repeat (3) run_txn(16'h0003, 1'b0, 0, 0, 1'b0);
    check("rr_three_frames_count", 32'(frame_count), 32'd3);

    // Pointer wrap: after node 15, node 0 wins over node 15.
    do_reset(1'b0);
    run_txn(16'h8000, 1'b0, 0, 0, 1'b0);
    run_txn(16'h8001, 1'b0, 0, 0, 1'b0);

    // Abort at bit 10, abort coinciding with the last bit, then a clean frame.
    do_reset(1'b0);
    run_txn(16'h0001, 1'b1, 10, 0, 1'b0);
    run_txn(16'h0001, 1'b1, FRAME_BITS - 1, 0, 1'b0);
    run_txn(16'h0001, 1'b0, 0, 0, 1'b0);

    // Reset at bit 40 of a frame overrides everything.
    do_reset(1'b0);
    run_txn(16'h0001, 1'b0, 0, 0, 1'b0);
    req = '0;
    repeat (4) @(posedge clock);
    #1;
    mon_en = 1'b0;
    req    = 16'h0001;
    wait_grant(16'h0001);
    repeat (40) @(posedge clock);
    #1;
    check("mid_frame_bit_cnt", 32'(bit_cnt), 32'd40);
    check("count_before_reset", 32'(frame_count), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frame_count", 32'(frame_count), 32'd0);
    check("midrst_bit_cnt", 32'(bit_cnt), 32'd0);
    @(posedge clock);
    #1;
    reset   = 1'b0;
    req     = '0;
    sb_q.delete();
    m_ptr   = 15;
    m_count = '0;
    mon_en  = 1'b1;
    run_txn(16'h0004, 1'b0, 0, 0, 1'b0);

    // All sixteen nodes requesting: grants in order 0..15.
    do_reset(1'b0);
    repeat (16) run_txn(16'hFFFF, 1'b0, 0, 0, 1'b0);

    // Randomised traffic with aborts, idle spells and non-owner request churn.
    for (int t = 0; t < 40; t++) begin
      r_mask = 16'($urandom);
      if (r_mask == '0) r_mask = 16'h0001 << $urandom_range(15, 0);
      r_abort = ($urandom_range(3, 0) == 0);
      r_at    = $urandom_range(FRAME_BITS - 1, 1);
      r_idle  = $urandom_range(3, 0);
      run_txn(r_mask, r_abort, r_at, r_idle, 1'b1);
    end

    req = '0;
    repeat (6) @(posedge clock);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
